// File: rtl/ir_key_decoder.sv
// Matches IR codes against a programmable code->key table and suppresses repeats inside a hold window.
// Decoded events go into a first-word-fall-through FIFO. Define IR_REPEAT_FLAG_EN to queue repeats tagged key_rpt=1.
module ir_key_decoder #(
  parameter int CODE_W      = 16,
  parameter int KEY_W       = 8,
  parameter int NUM_KEYS    = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CODE_W-1:0]           code_in,
  input  logic                        code_valid,
  input  logic                        tbl_wr_en,
  input  logic [$clog2(NUM_KEYS)-1:0] tbl_wr_idx,
  input  logic [CODE_W-1:0]           tbl_wr_code,
  input  logic [KEY_W-1:0]            tbl_wr_key,
  input  logic                        tbl_wr_vld,
  output logic [KEY_W-1:0]            key_out,
  output logic                        key_rpt,
  output logic                        key_valid,
  input  logic                        key_ready,
  output logic                        miss,
  output logic                        ovf,
  output logic                        hold_active
);

  localparam int IDX_W  = $clog2(NUM_KEYS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
`ifdef IR_REPEAT_FLAG_EN
  localparam int FIFO_W = KEY_W + 1;
`else
  localparam int FIFO_W = KEY_W;
`endif

  function automatic logic [CODE_W-1:0] dflt_code(input int i);
    case (i)
      0:       dflt_code = CODE_W'(16'h0A0B);
      1:       dflt_code = CODE_W'(16'h0A02);
      2:       dflt_code = CODE_W'(16'h0A04);
      3:       dflt_code = CODE_W'(16'h0A06);
      4:       dflt_code = CODE_W'(16'h0A08);
      5:       dflt_code = CODE_W'(16'h0A10);
      6:       dflt_code = CODE_W'(16'h0A0A);
      7:       dflt_code = CODE_W'(16'h0A12);
      default: dflt_code = '0;
    endcase
  endfunction

  function automatic logic [KEY_W-1:0] dflt_key(input int i);
    case (i)
      0:       dflt_key = KEY_W'(8'h01);
      1:       dflt_key = KEY_W'(8'h02);
      2:       dflt_key = KEY_W'(8'h05);
      3:       dflt_key = KEY_W'(8'h06);
      4:       dflt_key = KEY_W'(8'h07);
      5:       dflt_key = KEY_W'(8'h08);
      6:       dflt_key = KEY_W'(8'h09);
      7:       dflt_key = KEY_W'(8'h0A);
      default: dflt_key = '0;
    endcase
  endfunction

  logic [NUM_KEYS-1:0] hit_vec;
  logic [KEY_W-1:0]    key_arr [NUM_KEYS];
  logic                match_hit;
  logic [KEY_W-1:0]    match_key;

  // Table write lands at the edge, so a same-cycle lookup sees the old entry.
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_tbl
      logic [CODE_W-1:0] code_reg;
      logic [KEY_W-1:0]  key_reg;
      logic              vld_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          code_reg <= dflt_code(gi);
          key_reg  <= dflt_key(gi);
          vld_reg  <= (gi < 8);
        end else if (tbl_wr_en && tbl_wr_idx == IDX_W'(gi)) begin
          code_reg <= tbl_wr_code;
          key_reg  <= tbl_wr_key;
          vld_reg  <= tbl_wr_vld;
        end
      end

      assign hit_vec[gi] = vld_reg && (code_reg == code_in);
      assign key_arr[gi] = key_reg;
    end
  endgenerate

  always_comb begin
    match_hit = 1'b0;
    match_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        match_hit = 1'b1;
        match_key = key_arr[i];
      end
    end
  end

  logic             hit_reg;
  logic             miss_reg;
  logic [KEY_W-1:0] hit_key_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_reg     <= 1'b0;
      miss_reg    <= 1'b0;
      hit_key_reg <= '0;
    end else begin
      hit_reg     <= code_valid && match_hit;
      miss_reg    <= code_valid && !match_hit;
      hit_key_reg <= match_key;
    end
  end

  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [KEY_W-1:0]  last_key_reg;
  logic              last_vld_reg;
  logic              is_repeat;

  assign is_repeat = hit_reg && last_vld_reg && (hold_cnt_reg != '0) && (hit_key_reg == last_key_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_reg <= '0;
      last_key_reg <= '0;
      last_vld_reg <= 1'b0;
    end else if (hit_reg) begin
      hold_cnt_reg <= HOLD_W'(HOLD_CYCLES - 1);
      last_vld_reg <= 1'b1;
      if (!is_repeat) last_key_reg <= hit_key_reg;
    end else if (hold_cnt_reg != '0) begin
      hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
      if (hold_cnt_reg == HOLD_W'(1)) last_vld_reg <= 1'b0;
    end
  end

  logic              push;
  logic [FIFO_W-1:0] push_word;
`ifdef IR_REPEAT_FLAG_EN
  assign push      = hit_reg;
  assign push_word = {is_repeat, hit_key_reg};
`else
  assign push      = hit_reg && !is_repeat;
  assign push_word = hit_key_reg;
`endif

  logic [FIFO_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [FIFO_W-1:0] last_out_reg;
  logic              pop, full, wr_ok;
  logic [FIFO_W-1:0] head_word;

  assign pop   = (count_reg != '0) && key_ready;
  assign full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign wr_ok = push && (!full || pop);
  assign ovf   = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      last_out_reg <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
        last_out_reg <= mem[rd_ptr_reg];
      end
      if (wr_ok && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!wr_ok && pop) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Empty FIFO shows the most recently popped word rather than stale RAM.
  assign head_word   = (count_reg != '0) ? mem[rd_ptr_reg] : last_out_reg;
  assign key_out     = head_word[KEY_W-1:0];
`ifdef IR_REPEAT_FLAG_EN
  assign key_rpt     = head_word[KEY_W];
`else
  assign key_rpt     = 1'b0;
`endif
  assign key_valid   = (count_reg != '0);
  assign miss        = miss_reg;
  assign hold_active = (hold_cnt_reg != '0);

endmodule
